// File: rtl/calc_lamps_ctrl.sv
// Avalon-MM calculator: add/sub/mul/div on 16-bit operands, with the decimal
// result shown on six active-low 7-segment digits (leading zeros blanked).
module calc_lamps_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic [41:0] lamps
);

  typedef enum logic [2:0] {IDLE, EXEC, CHECK, CONV, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t      state, state_nx;
  op_t         op_snap;
  logic [15:0] opa, opb, a_snap, b_snap;
  logic [31:0] acc, mcand, exec_val;
  logic [15:0] mq;
  logic [16:0] rem, trial;
  logic [4:0]  cnt;
  logic        busy, err, done, err_flag, check_err, start;
  logic [19:0] result, res_hold;
  logic [43:0] dd, dd_adj;
  logic [41:0] lamps_nx;
  logic [3:0]  digit;
  logic        lead;
  logic        unused_wdata;

  assign unused_wdata = &{1'b0, writedata[31:16]};

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign start    = write && (address == 2'd2) && writedata[8] && (state == IDLE);
  // Division leaves its quotient in mq; everything else accumulates in acc.
  assign exec_val = (op_snap == OP_DIV) ? {16'h0, mq} : acc;
  assign check_err = ((op_snap == OP_SUB) && (a_snap < b_snap)) ||
                     ((op_snap == OP_DIV) && (b_snap == 16'h0)) ||
                     (exec_val > 32'd999999);
  assign trial    = {rem[15:0], mq[15]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = EXEC;
      EXEC:    if (op_snap == OP_ADD || op_snap == OP_SUB || cnt == 5'd15) state_nx = CHECK;
      CHECK:   state_nx = check_err ? DONE : CONV;
      CONV:    if (cnt == 5'd19) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Double-dabble: add 3 to every BCD digit >= 5 before each left shift.
  always_comb begin
    dd_adj = dd;
    for (int unsigned i = 0; i < 6; i++) begin
      if (dd[20+4*i +: 4] >= 4'd5) dd_adj[20+4*i +: 4] = dd[20+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    lamps_nx = '1;
    lead     = 1'b1;
    digit    = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      digit = dd[40-4*i +: 4];
      if (digit != 4'd0 || i == 5) lead = 1'b0;
      lamps_nx[35-7*i +: 7] = lead ? 7'h7F : seg7(digit);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa      <= '0;
      opb      <= '0;
      a_snap   <= '0;
      b_snap   <= '0;
      op_snap  <= OP_ADD;
      acc      <= '0;
      mcand    <= '0;
      mq       <= '0;
      rem      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      done     <= 1'b0;
      err_flag <= 1'b0;
      result   <= '0;
      res_hold <= '0;
      dd       <= '0;
      readdata <= '0;
      lamps    <= '1;
    end else begin
      if (write && address == 2'd0) opa <= writedata[15:0];
      if (write && address == 2'd1) opb <= writedata[15:0];
      if (read) begin
        case (address)
          2'd0:    readdata <= {16'h0, opa};
          2'd1:    readdata <= {16'h0, opb};
          2'd2:    readdata <= {29'h0, done, err, busy};
          default: readdata <= {12'h0, result};
        endcase
      end
      case (state)
        IDLE: begin
          if (start) begin
            a_snap   <= opa;
            b_snap   <= opb;
            op_snap  <= op_t'(writedata[1:0]);
            acc      <= '0;
            mcand    <= {16'h0, opa};
            mq       <= (writedata[1:0] == 2'd3) ? opa : opb;
            rem      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            err_flag <= 1'b0;
          end
        end
        EXEC: begin
          cnt <= cnt + 5'd1;
          case (op_snap)
            OP_ADD: acc <= {16'h0, a_snap} + {16'h0, b_snap};
            OP_SUB: acc <= {16'h0, a_snap} - {16'h0, b_snap};
            OP_MUL: begin
              if (mq[0]) acc <= acc + mcand;
              mcand <= {mcand[30:0], 1'b0};
              mq    <= {1'b0, mq[15:1]};
            end
            OP_DIV: begin
              if (trial >= {1'b0, b_snap}) begin
                rem <= trial - {1'b0, b_snap};
                mq  <= {mq[14:0], 1'b1};
              end else begin
                rem <= trial;
                mq  <= {mq[14:0], 1'b0};
              end
            end
          endcase
        end
        CHECK: begin
          err_flag <= check_err;
          res_hold <= exec_val[19:0];
          dd       <= {24'h0, exec_val[19:0]};
          cnt      <= '0;
        end
        CONV: begin
          dd  <= {dd_adj[42:0], 1'b0};
          cnt <= cnt + 5'd1;
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (err_flag) begin
            err    <= 1'b1;
            result <= '0;
            lamps  <= {6{7'h3F}};
          end else begin
            result <= res_hold;
            lamps  <= lamps_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_lamps_ctrl.sv
// Bench for calc_lamps_ctrl: directed cases with literal expectations, then a
// random bus mix checked every cycle against a latency-table arithmetic model.
module tb_calc_lamps_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  address = '0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic [41:0] lamps;

  int n_checks = 0;
  int n_fail = 0;

  calc_lamps_ctrl dut (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata), .lamps(lamps)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [41:0] dec_lamps(input longint v);
    logic [41:0] r;
    longint p;
    r = '1;
    p = 1;
    for (int k = 0; k < 6; k++) begin
      if (k == 0 || v >= p) r[7*k +: 7] = seg_tab[int'((v / p) % 10)];
      p = p * 10;
    end
    return r;
  endfunction

  logic [15:0] m_opa = '0, m_opb = '0;
  bit          m_busy = 0, m_err = 0, m_done = 0, m_was_busy = 0;
  logic [19:0] m_result = '0, p_res = '0;
  logic [41:0] m_lamps = '1, p_lamps = '1;
  bit          p_err = 0;
  int          m_cnt = 0;
  logic [31:0] m_rd = '0;
  bit          m_rd_chk = 0;

  task automatic model_start(input logic [1:0] op);
    longint a, b, v;
    bit e;
    a = longint'(m_opa);
    b = longint'(m_opb);
    v = 0;
    e = 0;
    case (op)
      2'd0: v = a + b;
      2'd1: begin e = (a < b); v = e ? 0 : a - b; end
      2'd2: v = a * b;
      default: begin e = (b == 0); v = e ? 0 : a / b; end
    endcase
    if (v > 999999) e = 1;
    p_err   = e;
    p_res   = e ? 20'h0 : 20'(v);
    p_lamps = e ? {6{7'h3F}} : dec_lamps(v);
    m_cnt   = e ? ((op < 2) ? 3 : 18) : ((op < 2) ? 23 : 38);
    m_busy  = 1;
    m_done  = 0;
    m_err   = 0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_opa = '0; m_opb = '0; m_busy = 0; m_err = 0; m_done = 0;
      m_result = '0; m_lamps = '1; m_cnt = 0; m_rd = '0; m_rd_chk = 0;
    end else begin
      m_rd_chk = read;
      if (read) begin
        case (address)
          2'd0:    m_rd = {16'h0, m_opa};
          2'd1:    m_rd = {16'h0, m_opb};
          2'd2:    m_rd = {29'h0, m_done, m_err, m_busy};
          default: m_rd = {12'h0, m_result};
        endcase
      end
      m_was_busy = m_busy;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0; m_done = 1; m_err = p_err; m_result = p_res; m_lamps = p_lamps;
        end
      end
      if (write) begin
        case (address)
          2'd0: m_opa = writedata[15:0];
          2'd1: m_opb = writedata[15:0];
          2'd2: if (writedata[8] && !m_was_busy) model_start(writedata[1:0]);
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    check("lamps", lamps, m_lamps);
    if (m_rd_chk) check("readdata", readdata, m_rd);
  end

  // ---------------- bus helpers ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  // Poll STATUS; a read issued at poll index k shows the state after edge k-1.
  task automatic wait_idle(input string name, input int k0, input int exp_lat);
    logic [31:0] d;
    int k;
    bit seen;
    k = k0;
    seen = 0;
    while (k <= 80 && !seen) begin
      bus_read(2'd2, d);
      if (!d[0]) seen = 1;
      else k++;
    end
    check({name, " latency"}, seen ? 64'(k - 1) : 64'hFFFF, 64'(exp_lat));
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op, input int exp_lat, input bit exp_err,
                        input logic [19:0] exp_res, input logic [41:0] exp_lamps);
    logic [31:0] d;
    bus_write(2'd0, {16'h0, a});
    bus_write(2'd1, {16'h0, b});
    bus_write(2'd2, {23'h0, 1'b1, 6'h0, op});
    wait_idle(name, 1, exp_lat);
    bus_read(2'd3, d);
    check({name, " result"}, d, {12'h0, exp_res});
    bus_read(2'd2, d);
    check({name, " status"}, d, {29'h0, 1'b1, exp_err, 1'b0});
    check({name, " lamps"}, lamps, exp_lamps);
  endtask

  function automatic logic [31:0] rand_opnd();
    logic [31:0] r;
    int sel;
    r = $urandom;
    sel = int'($urandom_range(0, 3));
    if (sel < 2)       r[15:0] = 16'($urandom_range(0, 999));
    else if (sel == 2) r[15:0] = 16'($urandom_range(0, 20));
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, w;
    int r;

    #1 reset_n = 1'b0;
    idle(3);
    check("reset lamps", lamps, 42'h3FFFFFFFFFF);
    check("reset readdata", readdata, 32'h0);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), d);
      check("reset reg", d, 32'h0);
    end

    run_op("add 1234+5678", 16'd1234, 16'd5678, 2'd0, 23, 1'b0, 20'd6912,
           {7'h7F, 7'h7F, 7'h02, 7'h10, 7'h79, 7'h24});
    run_op("mul 999x1001", 16'd999, 16'd1001, 2'd2, 38, 1'b0, 20'd999999, {6{7'h10}});
    run_op("mul 1000x1000", 16'd1000, 16'd1000, 2'd2, 18, 1'b1, 20'd0, {6{7'h3F}});
    run_op("div 65535/255", 16'd65535, 16'd255, 2'd3, 38, 1'b0, 20'd257,
           {7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h12, 7'h78});
    run_op("div 100/0", 16'd100, 16'd0, 2'd3, 18, 1'b1, 20'd0, {6{7'h3F}});
    run_op("sub 5-7", 16'd5, 16'd7, 2'd1, 3, 1'b1, 20'd0, {6{7'h3F}});
    run_op("sub 7-7", 16'd7, 16'd7, 2'd1, 23, 1'b0, 20'd0, {{5{7'h7F}}, 7'h40});

    // second start and OPA write while a mul is running
    bus_write(2'd0, 32'd300);
    bus_write(2'd1, 32'd200);
    bus_write(2'd2, 32'h102);
    idle(5);
    bus_write(2'd2, 32'h100);
    bus_write(2'd0, 32'd5);
    wait_idle("mid-mul start", 8, 38);
    bus_read(2'd3, d);
    check("mid-mul result", d, 32'd60000);
    check("mid-mul lamps", lamps, {7'h7F, 7'h02, 7'h40, 7'h40, 7'h40, 7'h40});
    bus_read(2'd0, d);
    check("mid-mul opa", d, 32'd5);

    // reset during EXEC of a mul
    bus_write(2'd0, 32'd300);
    bus_write(2'd2, 32'h102);
    idle(7);
    pulse_reset();
    check("abort lamps", lamps, 42'h3FFFFFFFFFF);
    bus_read(2'd2, d);
    check("abort status", d, 32'h0);
    idle(40);
    check("abort lamps later", lamps, 42'h3FFFFFFFFFF);
    run_op("add after reset", 16'd1, 16'd2, 2'd0, 23, 1'b0, 20'd3, {{5{7'h7F}}, 7'h30});

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 19));
      w = $urandom;
      if (r < 8)        bus_read(2'($urandom_range(0, 3)), d);
      else if (r < 10)  bus_write(2'd0, rand_opnd());
      else if (r < 12)  bus_write(2'd1, rand_opnd());
      else if (r < 14)  bus_write(2'd2, w | 32'h100);
      else if (r < 15)  bus_write(2'd2, w & ~32'h100);
      else if (r < 16)  bus_write(2'd3, w);
      else if (r == 16 && $urandom_range(0, 60) == 0) pulse_reset();
      else idle(1);
    end
    idle(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
